// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Takes the board/power-up reset and releases NSTAGES downstream resets one
//   after another. Each stage must acknowledge before the next one is
//   released. A missing or dropped acknowledge raises a sticky fault and puts
//   every stage back into reset. A software request restarts the sequence.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset (power-on / pin)
//   rst_n_out    per-stage active-low reset, bit k = stage k (registered)
//   stage_ack    per-stage ready level, asynchronous, synchronized here
//   soft_req     software restart request (pulse or level), sampled only
//                in DONE or FAULT
//   all_ready    every stage released and acknowledged
//   fault        sticky fault flag
//   fault_stage  index of the faulting stage, valid while fault = 1
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NSTAGES     = 3,
    parameter int HOLD_CYCLES = 64,
    parameter int STAGE_GAP   = 16,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    output logic [NSTAGES-1:0]                              rst_n_out,
    input  logic [NSTAGES-1:0]                              stage_ack,
    input  logic                                            soft_req,
    output logic                                            all_ready,
    output logic                                            fault,
    output logic [((NSTAGES > 1) ? $clog2(NSTAGES) : 1)-1:0] fault_stage
);

    localparam int FSW       = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam int CNT_MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > ACK_TIMEOUT) ? CNT_MAX_A : ACK_TIMEOUT;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LAST   = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0]  TO_LAST    = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : {CW{1'b0}};
    localparam logic           TO_EN      = (ACK_TIMEOUT != 0);
    localparam logic [FSW-1:0] LAST_STAGE = FSW'(NSTAGES - 1);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_GAP     = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    // One-hot mask with only bit idx set.
    function automatic logic [NSTAGES-1:0] stage_onehot(input logic [FSW-1:0] idx);
        logic [NSTAGES-1:0] oh;
        for (int j = 0; j < NSTAGES; j++) begin
            oh[j] = (FSW'(j) == idx);
        end
        return oh;
    endfunction

    // Index of the lowest zero bit (0 when none are zero).
    function automatic logic [FSW-1:0] lowest_zero(input logic [NSTAGES-1:0] v);
        logic [FSW-1:0] idx;
        idx = {FSW{1'b0}};
        for (int j = NSTAGES - 1; j >= 0; j--) begin
            if (!v[j]) begin
                idx = FSW'(j);
            end
        end
        return idx;
    endfunction

    logic [1:0]         rst_sync_q;
    logic               sync_n;
    logic [NSTAGES-1:0] ack_meta_q, ack_sync_q;
    logic               ack_k;

    state_e             state_q, state_d;
    logic [FSW-1:0]     stage_q, stage_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NSTAGES-1:0] rst_out_q, rst_out_d;
    logic               all_ready_q, all_ready_d;
    logic               fault_q, fault_d;
    logic [FSW-1:0]     fault_stage_q, fault_stage_d;

    assign sync_n      = rst_sync_q[1];
    assign ack_k       = ack_sync_q[stage_q];

    assign rst_n_out   = rst_out_q;
    assign all_ready   = all_ready_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;

    // Reset release synchronizer: assert asynchronously, deassert on clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // Two-flop synchronizer for the asynchronous stage acknowledges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= {NSTAGES{1'b0}};
            ack_sync_q <= {NSTAGES{1'b0}};
        end else begin
            ack_meta_q <= stage_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HOLD;
            stage_q       <= {FSW{1'b0}};
            cnt_q         <= {CW{1'b0}};
            rst_out_q     <= {NSTAGES{1'b0}};
            all_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= {FSW{1'b0}};
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            cnt_q         <= cnt_d;
            rst_out_q     <= rst_out_d;
            all_ready_q   <= all_ready_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one edge early so
    // they change exactly on the edge that enters the new state.
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        cnt_d         = cnt_q;
        rst_out_d     = rst_out_q;
        all_ready_d   = all_ready_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;

        if (!sync_n) begin
            // Reset still being synchronized: keep everything parked.
            state_d       = ST_HOLD;
            stage_d       = {FSW{1'b0}};
            cnt_d         = {CW{1'b0}};
            rst_out_d     = {NSTAGES{1'b0}};
            all_ready_d   = 1'b0;
            fault_d       = 1'b0;
            fault_stage_d = {FSW{1'b0}};
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d   = ST_RELEASE;
                        stage_d   = {FSW{1'b0}};
                        cnt_d     = {CW{1'b0}};
                        rst_out_d = rst_out_q | stage_onehot({FSW{1'b0}});
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (ack_k) begin
                        cnt_d = {CW{1'b0}};
                        if (stage_q == LAST_STAGE) begin
                            state_d     = ST_DONE;
                            all_ready_d = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_d       = ST_FAULT;
                        cnt_d         = {CW{1'b0}};
                        rst_out_d     = {NSTAGES{1'b0}};
                        fault_d       = 1'b1;
                        fault_stage_d = stage_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d   = ST_RELEASE;
                        stage_d   = stage_q + FSW'(1);
                        cnt_d     = {CW{1'b0}};
                        rst_out_d = rst_out_q | stage_onehot(stage_q + FSW'(1));
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    // A restart request takes precedence over a dropped ack.
                    if (soft_req) begin
                        state_d     = ST_HOLD;
                        stage_d     = {FSW{1'b0}};
                        cnt_d       = {CW{1'b0}};
                        rst_out_d   = {NSTAGES{1'b0}};
                        all_ready_d = 1'b0;
                        fault_d     = 1'b0;
                    end else if (!(&ack_sync_q)) begin
                        state_d       = ST_FAULT;
                        cnt_d         = {CW{1'b0}};
                        rst_out_d     = {NSTAGES{1'b0}};
                        all_ready_d   = 1'b0;
                        fault_d       = 1'b1;
                        fault_stage_d = lowest_zero(ack_sync_q);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_FAULT: begin
                    if (soft_req) begin
                        state_d     = ST_HOLD;
                        stage_d     = {FSW{1'b0}};
                        cnt_d       = {CW{1'b0}};
                        rst_out_d   = {NSTAGES{1'b0}};
                        all_ready_d = 1'b0;
                        fault_d     = 1'b0;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a full restart.
                    state_d       = ST_HOLD;
                    stage_d       = {FSW{1'b0}};
                    cnt_d         = {CW{1'b0}};
                    rst_out_d     = {NSTAGES{1'b0}};
                    all_ready_d   = 1'b0;
                    fault_d       = 1'b0;
                    fault_stage_d = {FSW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench. dut_a uses HOLD=4, GAP=2, TIMEOUT=8; dut_b is identical
//   except that the acknowledge timeout is disabled. Inputs are driven and
//   outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n_a, soft_a, rdy_a, flt_a;
    logic [2:0] ack_a, rst_a;
    logic [1:0] fs_a;

    logic       reset_n_b, soft_b, rdy_b, flt_b;
    logic [2:0] ack_b, rst_b;
    logic [1:0] fs_b;

    reset_sequencer #(
        .NSTAGES(3), .HOLD_CYCLES(4), .STAGE_GAP(2), .ACK_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset_n(reset_n_a), .rst_n_out(rst_a), .stage_ack(ack_a),
        .soft_req(soft_a), .all_ready(rdy_a), .fault(flt_a), .fault_stage(fs_a)
    );

    reset_sequencer #(
        .NSTAGES(3), .HOLD_CYCLES(4), .STAGE_GAP(2), .ACK_TIMEOUT(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n_b), .rst_n_out(rst_b), .stage_ack(ack_b),
        .soft_req(soft_b), .all_ready(rdy_b), .fault(flt_b), .fault_stage(fs_b)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected outputs after posedge 1..13 following reset_n release, acks tied high.
    logic [2:0] t1_rst [13] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b001, 3'b001, 3'b001,
                                3'b011, 3'b011, 3'b011,
                                3'b111, 3'b111};
    logic       t1_rdy [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset_n_a = 1'b0; soft_a = 1'b0; ack_a = 3'b111;
        reset_n_b = 1'b0; soft_b = 1'b0; ack_b = 3'b110;
        cycles(3);

        // Reset state
        check("rst_out_reset", 32'(rst_a), 32'h0);
        check("rdy_reset",     32'(rdy_a), 32'h0);
        check("fault_reset",   32'(flt_a), 32'h0);
        check("fstage_reset",  32'(fs_a),  32'h0);
        check("b_rst_reset",   32'(rst_b), 32'h0);

        // 1: normal staged release
        reset_n_a = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cycles(1);
            check("t1_rst",   32'(rst_a), 32'(t1_rst[i]));
            check("t1_rdy",   32'(rdy_a), 32'(t1_rdy[i]));
            check("t1_fault", 32'(flt_a), 32'h0);
        end

        // 2: stage 1 never acknowledges -> timeout fault
        reset_n_a = 1'b0; ack_a = 3'b101;
        cycles(2);
        reset_n_a = 1'b1;
        cycles(9);
        check("t2_rst_rel1",  32'(rst_a), 32'h3);
        cycles(7);
        check("t2_rst_wait",  32'(rst_a), 32'h3);
        check("t2_flt_wait",  32'(flt_a), 32'h0);
        cycles(1);
        check("t2_rst_flt",   32'(rst_a), 32'h0);
        check("t2_fault",     32'(flt_a), 32'h1);
        check("t2_fstage",    32'(fs_a),  32'h1);
        check("t2_rdy",       32'(rdy_a), 32'h0);
        ack_a = 3'b111;
        cycles(6);
        check("t2_late_rst",  32'(rst_a), 32'h0);
        check("t2_late_flt",  32'(flt_a), 32'h1);
        check("t2_late_fs",   32'(fs_a),  32'h1);

        // 3: soft restart from FAULT
        soft_a = 1'b1;
        cycles(1);
        soft_a = 1'b0;
        check("t3_flt_clr",   32'(flt_a), 32'h0);
        check("t3_rst_hold",  32'(rst_a), 32'h0);
        cycles(3);
        check("t3_rst_hold3", 32'(rst_a), 32'h0);
        cycles(1);
        check("t3_rst_rel0",  32'(rst_a), 32'h1);
        cycles(6);
        check("t3_rst_all",   32'(rst_a), 32'h7);
        check("t3_rdy_early", 32'(rdy_a), 32'h0);
        cycles(1);
        check("t3_rdy",       32'(rdy_a), 32'h1);
        check("t3_fault",     32'(flt_a), 32'h0);

        // 4: two acks drop in DONE -> lowest index reported
        ack_a = 3'b010;
        cycles(2);
        check("t4_rdy_sync",  32'(rdy_a), 32'h1);
        check("t4_flt_sync",  32'(flt_a), 32'h0);
        cycles(1);
        check("t4_fault",     32'(flt_a), 32'h1);
        check("t4_fstage",    32'(fs_a),  32'h0);
        check("t4_rst",       32'(rst_a), 32'h0);
        check("t4_rdy",       32'(rdy_a), 32'h0);

        // 5: asynchronous reset in the middle of a GAP
        ack_a = 3'b111;
        soft_a = 1'b1;
        cycles(1);
        soft_a = 1'b0;
        cycles(5);
        check("t5_rst_gap",   32'(rst_a), 32'h1);
        #2 reset_n_a = 1'b0;
        #1;
        check("t5_rst_async", 32'(rst_a), 32'h0);
        check("t5_rdy_async", 32'(rdy_a), 32'h0);
        check("t5_flt_async", 32'(flt_a), 32'h0);
        cycles(1);
        check("t5_rst_low",   32'(rst_a), 32'h0);
        reset_n_a = 1'b1;
        cycles(5);
        check("t5_rst_hold",  32'(rst_a), 32'h0);
        cycles(1);
        check("t5_rst_rel0",  32'(rst_a), 32'h1);

        // 6: timeout disabled, long wait for stage 0, soft_req ignored
        reset_n_b = 1'b1;
        cycles(6);
        check("t6_rst_rel0",  32'(rst_b), 32'h1);
        cycles(2000);
        soft_b = 1'b1;
        cycles(1);
        soft_b = 1'b0;
        cycles(1);
        check("t6_soft_ign",  32'(rst_b), 32'h1);
        check("t6_soft_flt",  32'(flt_b), 32'h0);
        cycles(2998);
        check("t6_rst_wait",  32'(rst_b), 32'h1);
        check("t6_flt_wait",  32'(flt_b), 32'h0);
        check("t6_rdy_wait",  32'(rdy_b), 32'h0);
        ack_b = 3'b111;
        cycles(4);
        check("t6_rst_gap",   32'(rst_b), 32'h1);
        cycles(1);
        check("t6_rst_rel1",  32'(rst_b), 32'h3);
        cycles(3);
        check("t6_rst_all",   32'(rst_b), 32'h7);
        cycles(1);
        check("t6_rdy",       32'(rdy_b), 32'h1);
        check("t6_fault",     32'(flt_b), 32'h0);
        check("t6_fstage",    32'(fs_b),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
